uart_io: RTL and testbench
==========================

Name: uart_io

Overview:
- Serial console peripheral on the CPU's I/O side: upstream producer of the keyboard byte and its ready flag, downstream consumer of the display byte and its strobe.
- RX path deserialises 8N1 frames from the pad into a one-byte holding register. That register drives the CPU keyboard input, and its full flag drives en_inp.
- TX path captures the CPU display byte on each en_out strobe into a small FIFO, then serialises it 8N1 to the pad.

Parameters:
- CLKS_PER_BIT, 104, clk cycles per serial bit; minimum 4.
- TX_DEPTH, 4, TX FIFO entries; must be a power of two, minimum 2.

Ports:
- clk  in  1  system clock, same clock as the CPU clkin.
- rst  in  1  asynchronous active-high reset.
- rx_i  in  1  serial input pad; idle high.
- tx_o  out  1  serial output pad; idle high.
- keyboard  out  8  received byte, to CPU keyboard.
- en_inp  out  1  holding register full, to CPU en_inp.
- inp_ack  in  1  one-cycle pulse from SoC glue when the CPU consumes the byte (INP executed).
- display  in  8  CPU display latch value.
- en_out  in  1  CPU output strobe; high for at least 1 clk.
- tx_busy  out  1  serialiser active or FIFO non-empty.
- tx_full  out  1  TX FIFO full.
- rx_overrun  out  1  sticky flag: a byte arrived while the holding register was full.

Behaviour:
- Reset (async, any state): tx_o=1, keyboard=0, en_inp=0, tx_busy=0, tx_full=0, rx_overrun=0. FIFO empty, both FSMs go to IDLE, baud counters=0.
- Mid-frame reset aborts the frame with no partial output. tx_o is 1 immediately.
- Bit timer: counts 0..CLKS_PER_BIT-1 and wraps. It restarts at each FSM state entry.
- RX synchroniser: rx_i passes through 2 flops (rx_s). All RX logic uses rx_s only.
- RX FSM states: IDLE, START, DATA, STOP.
  - IDLE -> START on rx_s==0.
  - START: sample at count CLKS_PER_BIT/2-1. If rx_s==1 (glitch), go to IDLE. Otherwise go to DATA with the timer realigned to mid-bit.
  - DATA: sample 8 bits LSB first, one every CLKS_PER_BIT clocks.
  - STOP: sample once at mid-bit. If rx_s==1, the frame is valid. If rx_s==0 (framing error), discard the byte and wait in STOP until rx_s==1, then go to IDLE.
- Valid frame delivery, on the clk after the stop sample:
  - If en_inp==0: keyboard<=byte, en_inp<=1.
  - If en_inp==1 and no inp_ack that cycle: byte dropped, keyboard unchanged, rx_overrun<=1.
  - If inp_ack coincides with delivery: byte loaded, en_inp stays 1, no overrun.
- inp_ack alone: en_inp<=0 and rx_overrun<=0 next clk. keyboard holds its value.
- inp_ack with en_inp==0 has no effect.
- TX capture: register en_out once (en_d). push = en_out & ~en_d, so one push per strobe however long en_out is high. display is sampled in the same cycle as the push.
- Push when full: byte dropped, unless a pop occurs in the same cycle, in which case the push is accepted.
- tx_full = (count==TX_DEPTH). Count width is clog2(TX_DEPTH)+1. Pointers wrap modulo TX_DEPTH.
- TX FSM states: IDLE, START, DATA, STOP.
  - IDLE with FIFO non-empty: pop into the shift register, go to START. tx_o=0 for CLKS_PER_BIT clocks.
  - DATA: 8 bits LSB first, each CLKS_PER_BIT clocks.
  - STOP: tx_o=1 for CLKS_PER_BIT clocks, then IDLE.
  - Back-to-back frames: at most 1 idle clk between frames.
- Latency: en_out rising edge to tx_o falling edge is at most 3 clk when the FIFO is empty and TX is idle.
- tx_busy = (state!=IDLE) | (count!=0). It is registered.

Decomposition:
- Package uart_io_pkg: typedef enum uart_state_e {IDLE, START, DATA, STOP}, shared by the RX and TX FSMs. Constant UART_DATA_BITS=8.
- One sub-module: io_fifo.
  - Synchronous FIFO parameterised WIDTH/DEPTH.
  - Ports: push, pop, wdata, rdata, count, full, empty.
  - Behaviour: same-cycle push+pop allowed when full.
- RX and TX FSMs live in uart_io itself.

Test Plan (bench CLKS_PER_BIT=4, TX_DEPTH=4):
- Send RX frame 0x5A -> 40 clk later keyboard=0x5A, en_inp=1, rx_overrun=0. Pulse inp_ack -> next clk en_inp=0, keyboard=0x5A.
- Send 0x11 then 0x22 with no ack -> keyboard=0x11, en_inp=1, rx_overrun=1. inp_ack clears both flags.
- 1-clk low glitch on rx_i -> no frame, en_inp stays 0. Frame 0x33 with stop bit 0 -> discarded, en_inp=0.
- display=0xA5, en_out high 3 clk -> exactly one frame on tx_o: 0,1,0,1,0,0,1,0,1,1 (start, LSB-first data, stop), 4 clk per bit. tx_busy falls after the stop bit.
- Five en_out strobes (0x01..0x05) issued 2 clk apart:
  - If the serialiser pops before strobe 5: 0x01..0x05 all transmitted.
  - If strobe 5 lands while full with no pop: 0x05 dropped, tx_full seen high.
- Assert rst mid TX data bit -> tx_o=1 immediately, FIFO empty. After release, a new strobe (display=0x7E) is sent cleanly.

Source files
------------

// File: rtl/uart_io_pkg.sv
// Shared types and constants for the uart_io serial console peripheral.
package uart_io_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_state_e;

  localparam int unsigned UART_DATA_BITS = 8;

endpackage

// File: rtl/io_fifo.sv
// Synchronous FIFO with first-word-fall-through read; push is accepted when full
// if a pop happens in the same cycle.
module io_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         wdata_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]   count_q;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == FULL_CNT);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (PTR_W+1)'(1);
        2'b01:   count_q <= count_q - (PTR_W+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/uart_io.sv
// 8N1 serial console: RX into a one-byte holding register for the CPU keyboard
// input, TX from the CPU display strobe through a small FIFO.
module uart_io
  import uart_io_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 104,
  parameter int unsigned TX_DEPTH     = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rx_i,
  output logic                      tx_o,
  output logic [UART_DATA_BITS-1:0] keyboard,
  output logic                      en_inp,
  input  logic                      inp_ack,
  input  logic [UART_DATA_BITS-1:0] display,
  input  logic                      en_out,
  output logic                      tx_busy,
  output logic                      tx_full,
  output logic                      rx_overrun
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [2:0]       BIDX_LAST = 3'(UART_DATA_BITS - 1);

  // RX synchroniser
  logic rx_meta_q, rx_s_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx_i;
      rx_s_q    <= rx_meta_q;
    end
  end

  uart_state_e               rx_state_q;
  logic [CNT_W-1:0]          rx_cnt_q;
  logic [2:0]                rx_bit_q;
  logic [UART_DATA_BITS-1:0] rx_shift_q;
  logic                      rx_ferr_q;
  logic                      rx_valid_q;

  // After the START check the timer restarts, so every later sample lands a
  // whole bit period after the mid-start sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_state_q <= IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_ferr_q  <= 1'b0;
      rx_valid_q <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;
      case (rx_state_q)
        IDLE: begin
          rx_cnt_q  <= '0;
          rx_ferr_q <= 1'b0;
          if (!rx_s_q) rx_state_q <= START;
        end
        START: begin
          if (rx_cnt_q == HALF_LAST) begin
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_state_q <= rx_s_q ? IDLE : DATA;
          end else begin
            rx_cnt_q <= rx_cnt_q + CNT_W'(1);
          end
        end
        DATA: begin
          if (rx_cnt_q == BIT_LAST) begin
            rx_cnt_q   <= '0;
            rx_shift_q <= {rx_s_q, rx_shift_q[UART_DATA_BITS-1:1]};
            rx_bit_q   <= rx_bit_q + 3'd1;
            if (rx_bit_q == BIDX_LAST) rx_state_q <= STOP;
          end else begin
            rx_cnt_q <= rx_cnt_q + CNT_W'(1);
          end
        end
        STOP: begin
          if (rx_ferr_q) begin
            if (rx_s_q) rx_state_q <= IDLE;
          end else if (rx_cnt_q == BIT_LAST) begin
            rx_cnt_q <= '0;
            if (rx_s_q) begin
              rx_valid_q <= 1'b1;
              rx_state_q <= IDLE;
            end else begin
              rx_ferr_q <= 1'b1;
            end
          end else begin
            rx_cnt_q <= rx_cnt_q + CNT_W'(1);
          end
        end
        default: rx_state_q <= IDLE;
      endcase
    end
  end

  // Holding register toward the CPU
  logic [UART_DATA_BITS-1:0] keyboard_q;
  logic                      en_inp_q;
  logic                      rx_overrun_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      keyboard_q   <= '0;
      en_inp_q     <= 1'b0;
      rx_overrun_q <= 1'b0;
    end else if (rx_valid_q) begin
      if (!en_inp_q || inp_ack) begin
        keyboard_q   <= rx_shift_q;
        en_inp_q     <= 1'b1;
        rx_overrun_q <= 1'b0;
      end else begin
        rx_overrun_q <= 1'b1;
      end
    end else if (inp_ack && en_inp_q) begin
      en_inp_q     <= 1'b0;
      rx_overrun_q <= 1'b0;
    end
  end

  assign keyboard   = keyboard_q;
  assign en_inp     = en_inp_q;
  assign rx_overrun = rx_overrun_q;

  // TX capture and FIFO
  logic                        en_out_q;
  logic                        tx_push, tx_pop;
  logic [UART_DATA_BITS-1:0]   fifo_rdata;
  logic [$clog2(TX_DEPTH):0]   fifo_count;
  logic                        fifo_full, fifo_empty;

  uart_state_e               tx_state_q;
  logic [CNT_W-1:0]          tx_cnt_q;
  logic [2:0]                tx_bit_q;
  logic [UART_DATA_BITS-1:0] tx_shift_q;
  logic                      tx_q;
  logic                      tx_busy_q;

  assign tx_push = en_out & ~en_out_q;
  assign tx_pop  = (tx_state_q == IDLE) & ~fifo_empty;

  io_fifo #(
    .WIDTH (UART_DATA_BITS),
    .DEPTH (TX_DEPTH)
  ) u_tx_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (tx_push),
    .pop_i   (tx_pop),
    .wdata_i (display),
    .rdata_o (fifo_rdata),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_out_q   <= 1'b0;
      tx_state_q <= IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      tx_q       <= 1'b1;
      tx_busy_q  <= 1'b0;
    end else begin
      en_out_q  <= en_out;
      tx_busy_q <= (tx_state_q != IDLE) | (fifo_count != '0);
      case (tx_state_q)
        IDLE: begin
          tx_cnt_q <= '0;
          tx_q     <= 1'b1;
          if (!fifo_empty) begin
            tx_shift_q <= fifo_rdata;
            tx_q       <= 1'b0;
            tx_state_q <= START;
          end
        end
        START: begin
          if (tx_cnt_q == BIT_LAST) begin
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_q       <= tx_shift_q[0];
            tx_shift_q <= {1'b0, tx_shift_q[UART_DATA_BITS-1:1]};
            tx_state_q <= DATA;
          end else begin
            tx_cnt_q <= tx_cnt_q + CNT_W'(1);
          end
        end
        DATA: begin
          if (tx_cnt_q == BIT_LAST) begin
            tx_cnt_q <= '0;
            tx_bit_q <= tx_bit_q + 3'd1;
            if (tx_bit_q == BIDX_LAST) begin
              tx_q       <= 1'b1;
              tx_state_q <= STOP;
            end else begin
              tx_q       <= tx_shift_q[0];
              tx_shift_q <= {1'b0, tx_shift_q[UART_DATA_BITS-1:1]};
            end
          end else begin
            tx_cnt_q <= tx_cnt_q + CNT_W'(1);
          end
        end
        STOP: begin
          if (tx_cnt_q == BIT_LAST) begin
            tx_cnt_q   <= '0;
            tx_state_q <= IDLE;
          end else begin
            tx_cnt_q <= tx_cnt_q + CNT_W'(1);
          end
        end
        default: tx_state_q <= IDLE;
      endcase
    end
  end

  assign tx_o    = tx_q;
  assign tx_busy = tx_busy_q;
  assign tx_full = fifo_full;

endmodule

// File: tb/tb_uart_io.sv
// Directed bench for uart_io with scoreboard queues for received and transmitted bytes.
module tb_uart_io;

  localparam int unsigned CPB   = 4;
  localparam int unsigned DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_i;
  logic       tx_o;
  logic [7:0] keyboard;
  logic       en_inp;
  logic       inp_ack;
  logic [7:0] display;
  logic       en_out;
  logic       tx_busy;
  logic       tx_full;
  logic       rx_overrun;

  int checks   = 0;
  int failures = 0;

  logic [7:0] tx_exp_q[$];
  logic [7:0] rx_exp_q[$];
  int         tx_frames  = 0;
  bit         mon_active = 1'b0;

  bit         m_full;
  logic [7:0] m_kb;

  uart_io #(
    .CLKS_PER_BIT (CPB),
    .TX_DEPTH     (DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_i       (rx_i),
    .tx_o       (tx_o),
    .keyboard   (keyboard),
    .en_inp     (en_inp),
    .inp_ack    (inp_ack),
    .display    (display),
    .en_out     (en_out),
    .tx_busy    (tx_busy),
    .tx_full    (tx_full),
    .rx_overrun (rx_overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic rx_send(input logic [7:0] b, input logic stop_bit);
    logic [9:0] f;
    f = {stop_bit, b, 1'b0};
    for (int s = 0; s < 10; s++) begin
      rx_i = f[s];
      repeat (CPB) @(negedge clk);
    end
    rx_i = 1'b1;
  endtask

  // Reference model of the holding register for a valid frame.
  task automatic rx_model(input logic [7:0] b, input bit ack_same);
    if (!m_full || ack_same) begin
      m_kb   = b;
      m_full = 1'b1;
      rx_exp_q.push_back(b);
    end
  endtask

  task automatic strobe(input logic [7:0] b, input int unsigned high_clks);
    display = b;
    en_out  = 1'b1;
    repeat (high_clks) @(negedge clk);
    en_out = 1'b0;
  endtask

  task automatic wait_tx_idle(input string tag, input int unsigned budget);
    bit done = 1'b0;
    for (int unsigned i = 0; i < budget; i++) begin
      if (tx_exp_q.size() == 0 && !mon_active && tx_busy === 1'b0) begin
        done = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk(tag, 64'(done), 64'd1);
  endtask

  // TX monitor: captures every cycle of a frame and compares against the
  // ideal 10-bit waveform of the next expected byte.
  initial begin : tx_monitor
    logic [39:0] obs, exp;
    logic [7:0]  b;
    bit          aborted, has_exp;
    int          slot;
    forever begin
      @(negedge clk);
      if (rst === 1'b0 && tx_o === 1'b0) begin
        mon_active = 1'b1;
        aborted    = 1'b0;
        has_exp    = (tx_exp_q.size() != 0);
        chk("tx_frame_expected", 64'(has_exp), 64'd1);
        b = has_exp ? tx_exp_q.pop_front() : 8'h00;
        obs    = '0;
        obs[0] = tx_o;
        for (int k = 1; k < 40; k++) begin
          @(negedge clk);
          if (rst !== 1'b0) begin
            aborted = 1'b1;
            break;
          end
          obs[k] = tx_o;
        end
        if (!aborted && has_exp) begin
          for (int k = 0; k < 40; k++) begin
            slot = k / 4;
            exp[k] = (slot == 0) ? 1'b0 : (slot == 9) ? 1'b1 : b[slot-1];
          end
          chk("tx_frame", 64'(obs), 64'(exp));
          tx_frames++;
        end
        mon_active = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    bit found;
    rst     = 1'b1;
    rx_i    = 1'b1;
    inp_ack = 1'b0;
    display = 8'h00;
    en_out  = 1'b0;
    m_full  = 1'b0;
    m_kb    = 8'h00;
    repeat (3) @(negedge clk);

    chk("rst_tx_o",       64'(tx_o),       64'd1);
    chk("rst_keyboard",   64'(keyboard),   64'd0);
    chk("rst_en_inp",     64'(en_inp),     64'd0);
    chk("rst_tx_busy",    64'(tx_busy),    64'd0);
    chk("rst_tx_full",    64'(tx_full),    64'd0);
    chk("rst_rx_overrun", 64'(rx_overrun), 64'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // RX: single frame then acknowledge
    rx_send(8'h5A, 1'b1);
    rx_model(8'h5A, 1'b0);
    repeat (4) @(negedge clk);
    chk("rx1_keyboard", 64'(keyboard),   64'(rx_exp_q.pop_front()));
    chk("rx1_en_inp",   64'(en_inp),     64'd1);
    chk("rx1_overrun",  64'(rx_overrun), 64'd0);
    inp_ack = 1'b1;
    @(negedge clk);
    inp_ack = 1'b0;
    m_full  = 1'b0;
    chk("rx1_ack_en_inp",   64'(en_inp),   64'd0);
    chk("rx1_ack_keyboard", 64'(keyboard), 64'(m_kb));

    // RX: second byte arrives while full
    rx_send(8'h11, 1'b1);
    rx_model(8'h11, 1'b0);
    repeat (2) @(negedge clk);
    rx_send(8'h22, 1'b1);
    rx_model(8'h22, 1'b0);
    repeat (4) @(negedge clk);
    chk("rx2_keyboard", 64'(keyboard),   64'(rx_exp_q.pop_front()));
    chk("rx2_en_inp",   64'(en_inp),     64'd1);
    chk("rx2_overrun",  64'(rx_overrun), 64'd1);
    inp_ack = 1'b1;
    @(negedge clk);
    inp_ack = 1'b0;
    m_full  = 1'b0;
    chk("rx2_ack_en_inp",  64'(en_inp),     64'd0);
    chk("rx2_ack_overrun", 64'(rx_overrun), 64'd0);

    // RX: start-bit glitch and framing error are both ignored
    rx_i = 1'b0;
    @(negedge clk);
    rx_i = 1'b1;
    repeat (20) @(negedge clk);
    chk("rx_glitch_en_inp",  64'(en_inp),     64'd0);
    chk("rx_glitch_overrun", 64'(rx_overrun), 64'd0);
    rx_send(8'h33, 1'b0);
    repeat (8) @(negedge clk);
    chk("rx_ferr_en_inp",   64'(en_inp),   64'd0);
    chk("rx_ferr_keyboard", 64'(keyboard), 64'(m_kb));

    // RX recovers after the framing error
    rx_send(8'h5C, 1'b1);
    rx_model(8'h5C, 1'b0);
    repeat (4) @(negedge clk);
    chk("rx3_keyboard", 64'(keyboard), 64'(rx_exp_q.pop_front()));
    chk("rx3_en_inp",   64'(en_inp),   64'd1);

    // RX: acknowledge lands on the delivery cycle
    rx_send(8'h66, 1'b1);
    rx_model(8'h66, 1'b1);
    @(negedge clk);
    inp_ack = 1'b1;
    @(negedge clk);
    inp_ack = 1'b0;
    repeat (2) @(negedge clk);
    chk("rx4_keyboard", 64'(keyboard),   64'(rx_exp_q.pop_front()));
    chk("rx4_en_inp",   64'(en_inp),     64'd1);
    chk("rx4_overrun",  64'(rx_overrun), 64'd0);

    // TX: single long strobe yields one frame with bounded latency
    display = 8'hA5;
    en_out  = 1'b1;
    tx_exp_q.push_back(8'hA5);
    found = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (tx_o === 1'b0) found = 1'b1;
    end
    en_out = 1'b0;
    chk("tx_latency", 64'(found), 64'd1);
    repeat (8) @(negedge clk);
    chk("tx_busy_mid", 64'(tx_busy), 64'd1);
    wait_tx_idle("tx_a5_drain", 200);
    chk("tx_a5_frames", 64'(tx_frames), 64'd1);
    chk("tx_idle_line", 64'(tx_o),      64'd1);

    // TX: first byte goes straight to the serialiser, four fill the FIFO, sixth is dropped
    for (int i = 1; i <= 5; i++) begin
      tx_exp_q.push_back(8'(i));
      strobe(8'(i), 1);
      @(negedge clk);
    end
    chk("tx_full_after5", 64'(tx_full), 64'd1);
    strobe(8'h06, 1);
    @(negedge clk);
    chk("tx_full_after6", 64'(tx_full), 64'd1);
    chk("tx_busy_burst",  64'(tx_busy), 64'd1);
    wait_tx_idle("tx_burst_drain", 400);
    chk("tx_burst_frames", 64'(tx_frames), 64'd6);
    chk("tx_full_drained", 64'(tx_full),   64'd0);

    // Reset in the middle of a data bit
    tx_exp_q.push_back(8'hC3);
    strobe(8'hC3, 1);
    @(negedge clk);
    tx_exp_q.push_back(8'h3C);
    strobe(8'h3C, 1);
    repeat (14) @(negedge clk);
    chk("tx_busy_prereset", 64'(tx_busy), 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_tx_o",     64'(tx_o),     64'd1);
    chk("rst_mid_tx_full",  64'(tx_full),  64'd0);
    chk("rst_mid_tx_busy",  64'(tx_busy),  64'd0);
    chk("rst_mid_keyboard", 64'(keyboard), 64'd0);
    chk("rst_mid_en_inp",   64'(en_inp),   64'd0);
    tx_exp_q.delete();
    rx_exp_q.delete();
    m_full = 1'b0;
    m_kb   = 8'h00;
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("post_rst_tx_busy", 64'(tx_busy), 64'd0);
    tx_exp_q.push_back(8'h7E);
    strobe(8'h7E, 2);
    wait_tx_idle("tx_7e_drain", 200);
    chk("tx_total_frames", 64'(tx_frames), 64'd7);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
